// File: rtl/rr_arb_n_lock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_n_lock_pkg
// Description : Shared router definitions for the output-port arbiter.
//               Direction indices (requester bit order at NUM_REQ=5) and the
//               arbiter lock-state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_arb_n_lock_pkg;

    // Requester / direction indices at the default five-port configuration
    localparam int DIR_PE  = 0;
    localparam int DIR_W   = 1;
    localparam int DIR_E   = 2;
    localparam int DIR_S   = 3;
    localparam int DIR_N   = 4;
    localparam int NUM_DIR = 5;

    // Arbiter state: IDLE arbitrates per flit, LOCKED holds the port for
    // the owner until its tail flit is accepted.
    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage : rr_arb_n_lock_pkg
`default_nettype wire

// File: rtl/rr_arb_n_lock_prio_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_prio_pick_n
// Description : Combinational rotating-priority picker. ptr is the highest
//               priority index; search runs ptr, ptr-1, ..., 0, NUM_REQ-1, ...
//               Implemented as double-width rotate, priority encode, and
//               un-rotate of the winning position.
// Ports       : req     [NUM_REQ] requests
//               ptr     [ID_W]    highest-priority index (must be < NUM_REQ)
//               pick    [NUM_REQ] one-hot winner (all zero when no request)
//               pick_id [ID_W]    binary index of winner (0 when none)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_prio_pick_n #(
    parameter  int NUM_REQ = 5,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [ID_W-1:0]    pick_id
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic                 w_found;
    int                   w_k_sel;
    int                   w_idx;

    // After shifting by ptr+1, w_rot[k] = req[(ptr+1+k) mod NUM_REQ], so
    // req[ptr] lands in the top bit and descending search order becomes a
    // plain top-down priority encode.
    assign w_dbl = {req, req};
    assign w_rot = NUM_REQ'(w_dbl >> (int'(ptr) + 1));

    always_comb begin
        w_found = 1'b0;
        w_k_sel = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_k_sel = k;
            end
        end

        // Map the rotated position back; sum is at most 2*NUM_REQ-1.
        w_idx = int'(ptr) + 1 + w_k_sel;
        if (w_idx >= NUM_REQ) begin
            w_idx = w_idx - NUM_REQ;
        end

        pick    = '0;
        pick_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick[i] = w_found && (w_idx == i);
        end
        if (w_found) begin
            pick_id = ID_W'(w_idx);
        end
    end

endmodule : rr_prio_pick_n
`default_nettype wire

// File: rtl/rr_arb_n_lock.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_n_lock
// Description : Round-robin arbiter for one router output port with wormhole
//               packet locking. Combinational one-hot grant gated by
//               outbuf_full; registered rotating pointer and lock owner.
//               Compile-time option: ARB_PKT_LOCK_EN
//                 defined   - granted input keeps the port until its tail
//                             flit is accepted
//                 undefined - req_tail ignored, pure per-flit round-robin,
//                             locked/owner_id tied to 0
// Ports       : clk, reset (async active-high)
//               req, req_tail [NUM_REQ], outbuf_full
//               gnt [NUM_REQ], gnt_vld, gnt_id [ID_W]
//               locked, owner_id [ID_W] (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_n_lock
    import rr_arb_n_lock_pkg::*;
#(
    parameter  int NUM_REQ = 5,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_tail,
    input  logic               outbuf_full,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_vld,
    output logic [ID_W-1:0]    gnt_id,
    output logic               locked,
    output logic [ID_W-1:0]    owner_id
);

    arb_state_t          state_q, state_d;
    logic [ID_W-1:0]     ptr_q,   ptr_d;
    logic [ID_W-1:0]     owner_q, owner_d;

    logic [NUM_REQ-1:0]  w_pick;
    logic [ID_W-1:0]     w_pick_id;
    logic [NUM_REQ-1:0]  w_owner_oh;
    logic [NUM_REQ-1:0]  w_gnt_raw;
    logic [ID_W-1:0]     w_id_raw;
    logic                w_tail;

    rr_prio_pick_n #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .pick    (w_pick),
        .pick_id (w_pick_id)
    );

    // Grant path: IDLE takes the rotating pick, LOCKED serves only the owner.
    // Reset also gates the grant so nothing is accepted while it is held.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_owner_oh[i] = (owner_q == ID_W'(i));
        end

        w_gnt_raw = '0;
        w_id_raw  = '0;
        if (state_q == ARB_IDLE) begin
            w_gnt_raw = w_pick;
            w_id_raw  = w_pick_id;
        end else begin
            w_gnt_raw = w_owner_oh & req;
            w_id_raw  = owner_q;
        end

        gnt     = (outbuf_full || reset) ? '0 : w_gnt_raw;
        gnt_vld = |gnt;
        gnt_id  = gnt_vld ? w_id_raw : '0;
    end

`ifdef ARB_PKT_LOCK_EN
    assign w_tail = |(gnt & req_tail);
`else
    // Every accepted flit ends its packet, so the lock is never taken.
    assign w_tail = 1'b1;
    logic w_unused_tail;
    assign w_unused_tail = ^req_tail;
`endif

    // Next state: only an accepted flit moves state, pointer or owner.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (gnt_vld) begin
            if (w_tail) begin
                state_d = ARB_IDLE;
                ptr_d   = (gnt_id == '0) ? ID_W'(NUM_REQ - 1) : (gnt_id - ID_W'(1));
            end else begin
                state_d = ARB_LOCKED;
                owner_d = gnt_id;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

`ifdef ARB_PKT_LOCK_EN
    assign locked   = (state_q == ARB_LOCKED);
    assign owner_id = owner_q;
`else
    assign locked   = 1'b0;
    assign owner_id = '0;
`endif

endmodule : rr_arb_n_lock
`default_nettype wire
